// File: rtl/axi_ar_arbiter.sv
// Two-master AXI read-address arbiter with per-master outstanding-burst limits
// and an ID-routed R return path. Define AXI_ARB_FIXED_PRIO_EN for fixed priority.
module axi_ar_arbiter #(
  parameter int C_AXI_ID_WIDTH   = 6,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_LEN_WIDTH  = 8,
  parameter int MAX_OUTST        = 4
) (
  input  logic                          i_clk,
  input  logic                          i_axi_reset_n,
  input  logic [1:0]                    s_arvalid,
  output logic [1:0]                    s_arready,
  input  logic [2*C_AXI_ID_WIDTH-1:0]   s_arid,
  input  logic [2*C_AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [2*C_AXI_LEN_WIDTH-1:0]  s_arlen,
  output logic [1:0]                    s_rvalid,
  input  logic [1:0]                    s_rready,
  output logic [C_AXI_ID_WIDTH-1:0]     s_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic                          s_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [C_AXI_ID_WIDTH:0]       m_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_araddr,
  output logic [C_AXI_LEN_WIDTH-1:0]    m_arlen,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [C_AXI_ID_WIDTH:0]       m_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_rdata,
  input  logic                          m_rlast
);

  localparam int ID = C_AXI_ID_WIDTH;
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int LW = C_AXI_LEN_WIDTH;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state;
  logic          grant;
  logic          next_grant;
  logic [1:0]    eligible;
  logic          ar_fire;
  logic          r_sel;
  logic          r_done;
  logic [CW-1:0] outst [2];

  always_comb begin
    eligible[0] = s_arvalid[0] && (outst[0] < MAX_CNT);
    eligible[1] = s_arvalid[1] && (outst[1] < MAX_CNT);
  end

`ifdef AXI_ARB_FIXED_PRIO_EN
  always_comb begin
    next_grant = !eligible[0];
  end
`else
  logic last_ptr;

  // Tie goes to the master that was not granted last; reset value 1 favours master 0.
  always_comb begin
    next_grant = eligible[1];
    if (&eligible) next_grant = ~last_ptr;
  end

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n)  last_ptr <= 1'b1;
    else if (ar_fire)    last_ptr <= grant;
  end
`endif

  // The grant is latched on entry to GRANT and held until the downstream handshake.
  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      state <= S_IDLE;
      grant <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|eligible) begin
            state <= S_GRANT;
            grant <= next_grant;
          end
        end
        default: begin
          if (m_arready) state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    m_arvalid = (state == S_GRANT);
    m_arid    = grant ? {1'b1, s_arid[2*ID-1:ID]} : {1'b0, s_arid[ID-1:0]};
    m_araddr  = grant ? s_araddr[2*AW-1:AW] : s_araddr[AW-1:0];
    m_arlen   = grant ? s_arlen[2*LW-1:LW]  : s_arlen[LW-1:0];
    s_arready = 2'b00;
    if (m_arvalid) s_arready[grant] = m_arready;
    ar_fire   = m_arvalid && m_arready;
  end

  // The MSB of the downstream RID names the master that owns the beat.
  always_comb begin
    r_sel    = m_rid[ID];
    s_rvalid = {m_rvalid && r_sel, m_rvalid && !r_sel};
    m_rready = s_rready[r_sel];
    s_rid    = m_rid[ID-1:0];
    s_rdata  = m_rdata;
    s_rlast  = m_rlast;
    r_done   = m_rvalid && m_rready && m_rlast;
  end

  for (genvar i = 0; i < 2; i++) begin : g_outst
    localparam logic IDX = 1'(i);
    logic inc;
    logic dec;

    assign inc = ar_fire && (grant == IDX);
    assign dec = r_done && (r_sel == IDX);

    // A burst issued and one retired in the same cycle cancel out.
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
      if (!i_axi_reset_n)
        outst[i] <= '0;
      else if (inc && !dec && outst[i] < MAX_CNT)
        outst[i] <= outst[i] + 1'b1;
      else if (dec && !inc && outst[i] != '0)
        outst[i] <= outst[i] - 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed self-checking bench for axi_ar_arbiter (default round-robin build).
module tb_axi_ar_arbiter;

  logic        i_clk = 1'b0;
  logic        i_axi_reset_n;
  logic [1:0]  s_arvalid;
  logic [1:0]  s_arready;
  logic [11:0] s_arid;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [1:0]  s_rvalid;
  logic [1:0]  s_rready;
  logic [5:0]  s_rid;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic        m_arvalid;
  logic        m_arready;
  logic [6:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_rvalid;
  logic        m_rready;
  logic [6:0]  m_rid;
  logic [31:0] m_rdata;
  logic        m_rlast;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [5:0]  ID0   = 6'h11;
  localparam logic [5:0]  ID1   = 6'h22;
  localparam logic [31:0] ADDR0 = 32'h1000_0000;
  localparam logic [31:0] ADDR1 = 32'h2000_0040;
  localparam logic [7:0]  LEN0  = 8'h03;
  localparam logic [7:0]  LEN1  = 8'h07;

  axi_ar_arbiter dut (
    .i_clk(i_clk), .i_axi_reset_n(i_axi_reset_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rlast(m_rlast)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] arvalid, input logic arready);
    s_arvalid = arvalid;
    m_arready = arready;
    #1;
  endtask

  task automatic applyR(input logic valid, input logic [6:0] rid,
                        input logic last, input logic [1:0] rready);
    m_rvalid = valid;
    m_rid    = rid;
    m_rlast  = last;
    s_rready = rready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    i_axi_reset_n = 1'b0;
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    s_arid    = {ID1, ID0};
    s_araddr  = {ADDR1, ADDR0};
    s_arlen   = {LEN1, LEN0};
    s_rready  = 2'b00;
    m_rvalid  = 1'b0;
    m_rid     = 7'h00;
    m_rdata   = 32'h0;
    m_rlast   = 1'b0;

    // Requests while held in reset must not produce a grant.
    applyStimulus(2'b11, 1'b1);
    tick();
    checkOutput("reset_arvalid", 64'(m_arvalid), 64'd0);
    checkOutput("reset_arready", 64'(s_arready), 64'd0);

    @(negedge i_clk);
    i_axi_reset_n = 1'b1;
    #1;
    checkOutput("idle_arvalid", 64'(m_arvalid), 64'd0);

    // Both masters request: master 0 first, then master 1.
    tick();
    checkOutput("rr_first_arvalid", 64'(m_arvalid), 64'd1);
    checkOutput("rr_first_arid", 64'(m_arid), 64'h11);
    checkOutput("rr_first_araddr", 64'(m_araddr), 64'(ADDR0));
    checkOutput("rr_first_arlen", 64'(m_arlen), 64'(LEN0));
    checkOutput("rr_first_arready", 64'(s_arready), 64'b01);
    tick();
    checkOutput("rr_gap_arvalid", 64'(m_arvalid), 64'd0);
    checkOutput("rr_gap_arready", 64'(s_arready), 64'd0);
    tick();
    checkOutput("rr_second_arid", 64'(m_arid), 64'h62);
    checkOutput("rr_second_araddr", 64'(m_araddr), 64'(ADDR1));
    checkOutput("rr_second_arlen", 64'(m_arlen), 64'(LEN1));
    checkOutput("rr_second_arready", 64'(s_arready), 64'b10);
    applyStimulus(2'b00, 1'b1);
    tick();
    checkOutput("rr_done_arvalid", 64'(m_arvalid), 64'd0);

    // R routing by RID MSB.
    m_rdata = 32'hDEAD_BEEF;
    applyR(1'b1, 7'h45, 1'b0, 2'b10);
    checkOutput("r_svalid_m1", 64'(s_rvalid), 64'b10);
    checkOutput("r_srid", 64'(s_rid), 64'h05);
    checkOutput("r_rdata", 64'(s_rdata), 64'hDEAD_BEEF);
    checkOutput("r_mready_hi", 64'(m_rready), 64'd1);
    applyR(1'b1, 7'h45, 1'b0, 2'b01);
    checkOutput("r_mready_lo", 64'(m_rready), 64'd0);
    applyR(1'b1, 7'h45, 1'b1, 2'b10);
    checkOutput("r_rlast", 64'(s_rlast), 64'd1);
    tick();
    applyR(1'b1, 7'h05, 1'b1, 2'b01);
    checkOutput("r_svalid_m0", 64'(s_rvalid), 64'b01);
    checkOutput("r_mready_m0", 64'(m_rready), 64'd1);
    tick();
    tick();
    applyR(1'b0, 7'h00, 1'b0, 2'b00);

    // Stall in GRANT with the other master also requesting.
    applyStimulus(2'b11, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_arvalid", 64'(m_arvalid), 64'd1);
      checkOutput("stall_arid", 64'(m_arid), 64'h11);
      checkOutput("stall_araddr", 64'(m_araddr), 64'(ADDR0));
      checkOutput("stall_arready", 64'(s_arready), 64'b00);
      tick();
    end
    applyStimulus(2'b11, 1'b1);
    checkOutput("stall_release_arready", 64'(s_arready), 64'b01);
    tick();

    // Master 0 fills its outstanding window (one already issued).
    applyStimulus(2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("fill_arid", 64'(m_arid), 64'h11);
      tick();
    end
    applyStimulus(2'b11, 1'b1);
    tick();
    checkOutput("full_other_arid", 64'(m_arid), 64'h62);
    applyStimulus(2'b01, 1'b1);
    tick();
    checkOutput("full_after_hs_arvalid", 64'(m_arvalid), 64'd0);
    tick();
    checkOutput("full_blocked_arvalid", 64'(m_arvalid), 64'd0);

    applyR(1'b1, 7'h00, 1'b1, 2'b01);
    tick();
    checkOutput("retire_same_edge_arvalid", 64'(m_arvalid), 64'd0);
    applyR(1'b0, 7'h00, 1'b0, 2'b00);
    tick();
    checkOutput("retire_grant_arvalid", 64'(m_arvalid), 64'd1);
    checkOutput("retire_grant_arid", 64'(m_arid), 64'h11);
    applyStimulus(2'b00, 1'b1);
    tick();

    // Bring master 0 down to two outstanding.
    applyR(1'b1, 7'h00, 1'b1, 2'b01);
    tick();
    tick();
    applyR(1'b0, 7'h00, 1'b0, 2'b00);

    // Issue and retire on the same edge: count must stay at two.
    applyStimulus(2'b01, 1'b1);
    tick();
    checkOutput("simul_grant_arvalid", 64'(m_arvalid), 64'd1);
    applyStimulus(2'b00, 1'b1);
    applyR(1'b1, 7'h00, 1'b1, 2'b01);
    tick();
    applyR(1'b0, 7'h00, 1'b0, 2'b00);
    applyStimulus(2'b01, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("simul_room_arvalid", 64'(m_arvalid), 64'd1);
      tick();
    end
    tick();
    checkOutput("simul_full_arvalid", 64'(m_arvalid), 64'd0);

    // Reset in the middle of a grant.
    applyStimulus(2'b10, 1'b0);
    tick();
    checkOutput("pre_reset_arid", 64'(m_arid), 64'h62);
    i_axi_reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_arvalid", 64'(m_arvalid), 64'd0);
    checkOutput("mid_reset_arready", 64'(s_arready), 64'd0);
    applyStimulus(2'b11, 1'b1);
    @(negedge i_clk);
    i_axi_reset_n = 1'b1;
    tick();
    checkOutput("post_reset_arvalid", 64'(m_arvalid), 64'd1);
    checkOutput("post_reset_arid", 64'(m_arid), 64'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
